// File: rtl/fifo_queue_32_bit.sv
// Synchronous FIFO with registered read data and combinational empty/full flags.
// Define FIFO_QUEUE_ERR_FLAGS_EN to add one-cycle Overflow_Out/Underflow_Out pulses.
module fifo_queue_32_bit #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  Write_Enable_In,
  input  logic                  Read_Enable_In,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic                  FIFO_Empty,
  output logic                  FIFO_Full
`ifdef FIFO_QUEUE_ERR_FLAGS_EN
  ,
  output logic                  Overflow_Out,
  output logic                  Underflow_Out
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  rd_ok, wr_ok;

  assign FIFO_Empty = (count_q == '0);
  assign FIFO_Full  = (count_q == CNT_W'(DEPTH));

  // A read frees a slot on the same edge, so a full FIFO can still take a write
  // alongside it; an empty FIFO never services the read half of a read+write.
  assign rd_ok = Read_Enable_In && !FIFO_Empty;
  assign wr_ok = Write_Enable_In && (!FIFO_Full || rd_ok);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    if (wr_ok) begin
      wr_ptr_d = (wr_ptr_q == CNT_W'(DEPTH - 1)) ? '0 : wr_ptr_q + CNT_W'(1);
    end
    if (rd_ok) begin
      rd_ptr_d   = (rd_ptr_q == CNT_W'(DEPTH - 1)) ? '0 : rd_ptr_q + CNT_W'(1);
      data_out_d = mem_q[rd_ptr_q[AW-1:0]];
    end
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage is deliberately left out of reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge Clk_In) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= Data_In;
    end
  end

  assign Data_Out = data_out_q;

`ifdef FIFO_QUEUE_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= Write_Enable_In && !wr_ok;
      underflow_q <= Read_Enable_In && !rd_ok;
    end
  end

  assign Overflow_Out  = overflow_q;
  assign Underflow_Out = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_queue_32_bit.sv
// Directed bench for fifo_queue_32_bit: reset, fill/overflow, drain/underflow,
// concurrent read+write across wrap, and asynchronous mid-cycle reset.
module tb_fifo_queue_32_bit;

  logic        Clk_In = 1'b0;
  logic        Reset_In = 1'b1;
  logic [31:0] Data_In = '0;
  logic        Write_Enable_In = 1'b0;
  logic        Read_Enable_In = 1'b0;
  logic [31:0] Data_Out;
  logic        FIFO_Empty;
  logic        FIFO_Full;
`ifdef FIFO_QUEUE_ERR_FLAGS_EN
  logic        Overflow_Out;
  logic        Underflow_Out;
`endif

  int vectors = 0;
  int miscompares = 0;

  fifo_queue_32_bit #(.DATA_WIDTH(32), .DEPTH(8)) dut (
    .Clk_In          (Clk_In),
    .Reset_In        (Reset_In),
    .Data_In         (Data_In),
    .Write_Enable_In (Write_Enable_In),
    .Read_Enable_In  (Read_Enable_In),
    .Data_Out        (Data_Out),
    .FIFO_Empty      (FIFO_Empty),
    .FIFO_Full       (FIFO_Full)
`ifdef FIFO_QUEUE_ERR_FLAGS_EN
    ,
    .Overflow_Out    (Overflow_Out),
    .Underflow_Out   (Underflow_Out)
`endif
  );

  always #5 Clk_In = ~Clk_In;

  task automatic tick;
    @(posedge Clk_In);
    #1;
  endtask

  task automatic test_reset;
    #1 Reset_In = 1'b0;
    #1;
    vectors++;
    if (FIFO_Empty !== 1'b1) begin
      miscompares++; $display("FAIL reset_empty: got %b expected 1", FIFO_Empty);
    end
    vectors++;
    if (FIFO_Full !== 1'b0) begin
      miscompares++; $display("FAIL reset_full: got %b expected 0", FIFO_Full);
    end
    vectors++;
    if (Data_Out !== 32'h0) begin
      miscompares++; $display("FAIL reset_data: got %h expected 00000000", Data_Out);
    end
    tick();
    tick();
    Reset_In = 1'b1;
  endtask

  task automatic test_empty_read;
    Read_Enable_In = 1'b1;
    tick();
    Read_Enable_In = 1'b0;
    vectors++;
    if (Data_Out !== 32'h0) begin
      miscompares++; $display("FAIL empty_read_data: got %h expected 00000000", Data_Out);
    end
    vectors++;
    if (FIFO_Empty !== 1'b1) begin
      miscompares++; $display("FAIL empty_read_empty: got %b expected 1", FIFO_Empty);
    end
`ifdef FIFO_QUEUE_ERR_FLAGS_EN
    vectors++;
    if (Underflow_Out !== 1'b1) begin
      miscompares++; $display("FAIL underflow_pulse: got %b expected 1", Underflow_Out);
    end
    tick();
    vectors++;
    if (Underflow_Out !== 1'b0) begin
      miscompares++; $display("FAIL underflow_clear: got %b expected 0", Underflow_Out);
    end
`endif
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 8; i++) begin
      Write_Enable_In = 1'b1;
      Data_In = 32'h11111111 * i;
      tick();
      vectors++;
      if (FIFO_Empty !== 1'b0) begin
        miscompares++; $display("FAIL fill_empty[%0d]: got %b expected 0", i, FIFO_Empty);
      end
      vectors++;
      if (FIFO_Full !== (i == 8)) begin
        miscompares++; $display("FAIL fill_full[%0d]: got %b expected %b", i, FIFO_Full, i == 8);
      end
    end
    Write_Enable_In = 1'b0;
  endtask

  task automatic test_overflow;
    Write_Enable_In = 1'b1;
    Data_In = 32'hDEADBEEF;
    tick();
    Write_Enable_In = 1'b0;
    Data_In = '0;
    vectors++;
    if (FIFO_Full !== 1'b1) begin
      miscompares++; $display("FAIL overflow_full: got %b expected 1", FIFO_Full);
    end
`ifdef FIFO_QUEUE_ERR_FLAGS_EN
    vectors++;
    if (Overflow_Out !== 1'b1) begin
      miscompares++; $display("FAIL overflow_pulse: got %b expected 1", Overflow_Out);
    end
`endif
  endtask

  task automatic test_drain;
    for (int i = 1; i <= 8; i++) begin
      Read_Enable_In = 1'b1;
      tick();
      vectors++;
      if (Data_Out !== 32'h11111111 * i) begin
        miscompares++;
        $display("FAIL drain_data[%0d]: got %h expected %h", i, Data_Out, 32'h11111111 * i);
      end
      vectors++;
      if (FIFO_Empty !== (i == 8)) begin
        miscompares++; $display("FAIL drain_empty[%0d]: got %b expected %b", i, FIFO_Empty, i == 8);
      end
`ifdef FIFO_QUEUE_ERR_FLAGS_EN
      if (i == 1) begin
        vectors++;
        if (Overflow_Out !== 1'b0) begin
          miscompares++; $display("FAIL overflow_clear: got %b expected 0", Overflow_Out);
        end
      end
`endif
    end
    tick();
    Read_Enable_In = 1'b0;
    vectors++;
    if (Data_Out !== 32'h88888888) begin
      miscompares++; $display("FAIL ninth_read_data: got %h expected 88888888", Data_Out);
    end
    vectors++;
    if (FIFO_Empty !== 1'b1) begin
      miscompares++; $display("FAIL ninth_read_empty: got %b expected 1", FIFO_Empty);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] q[$];
    logic [31:0] exp;
    for (int i = 0; i < 3; i++) begin
      Write_Enable_In = 1'b1;
      Data_In = 32'hA0000000 + i;
      q.push_back(Data_In);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      Write_Enable_In = 1'b1;
      Read_Enable_In = 1'b1;
      Data_In = 32'hB0000000 + i;
      exp = q.pop_front();
      q.push_back(Data_In);
      tick();
      vectors++;
      if (Data_Out !== exp) begin
        miscompares++; $display("FAIL rw3_data[%0d]: got %h expected %h", i, Data_Out, exp);
      end
      vectors++;
      if (FIFO_Empty !== 1'b0 || FIFO_Full !== 1'b0) begin
        miscompares++;
        $display("FAIL rw3_flags[%0d]: got empty=%b full=%b expected empty=0 full=0", i, FIFO_Empty, FIFO_Full);
      end
    end
    Read_Enable_In = 1'b0;
    for (int i = 0; i < 5; i++) begin
      Data_In = 32'hC0000000 + i;
      q.push_back(Data_In);
      tick();
    end
    vectors++;
    if (FIFO_Full !== 1'b1) begin
      miscompares++; $display("FAIL refill_full: got %b expected 1", FIFO_Full);
    end
    for (int i = 0; i < 8; i++) begin
      Read_Enable_In = 1'b1;
      Data_In = 32'hD0000000 + i;
      exp = q.pop_front();
      q.push_back(Data_In);
      tick();
      vectors++;
      if (Data_Out !== exp) begin
        miscompares++; $display("FAIL rwfull_data[%0d]: got %h expected %h", i, Data_Out, exp);
      end
      vectors++;
      if (FIFO_Full !== 1'b1) begin
        miscompares++; $display("FAIL rwfull_full[%0d]: got %b expected 1", i, FIFO_Full);
      end
    end
    Write_Enable_In = 1'b0;
    Read_Enable_In = 1'b0;
    Data_In = '0;
  endtask

  task automatic test_async_reset;
    Read_Enable_In = 1'b1;
    tick();
    tick();
    tick();
    Read_Enable_In = 1'b0;
    vectors++;
    if (Data_Out !== 32'hD0000002 || FIFO_Empty !== 1'b0) begin
      miscompares++;
      $display("FAIL occ5_state: got data=%h empty=%b expected data=d0000002 empty=0", Data_Out, FIFO_Empty);
    end
    #2 Reset_In = 1'b0;
    #1;
    vectors++;
    if (FIFO_Empty !== 1'b1) begin
      miscompares++; $display("FAIL async_reset_empty: got %b expected 1", FIFO_Empty);
    end
    vectors++;
    if (Data_Out !== 32'h0) begin
      miscompares++; $display("FAIL async_reset_data: got %h expected 00000000", Data_Out);
    end
    vectors++;
    if (FIFO_Full !== 1'b0) begin
      miscompares++; $display("FAIL async_reset_full: got %b expected 0", FIFO_Full);
    end
    tick();
    Reset_In = 1'b1;
    Read_Enable_In = 1'b1;
    tick();
    vectors++;
    if (Data_Out !== 32'h0 || FIFO_Empty !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_read: got data=%h empty=%b expected data=00000000 empty=1", Data_Out, FIFO_Empty);
    end
    Read_Enable_In = 1'b0;
    Write_Enable_In = 1'b1;
    Data_In = 32'h12345678;
    tick();
    Write_Enable_In = 1'b0;
    Read_Enable_In = 1'b1;
    tick();
    Read_Enable_In = 1'b0;
    vectors++;
    if (Data_Out !== 32'h12345678 || FIFO_Empty !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_rw: got data=%h empty=%b expected data=12345678 empty=1", Data_Out, FIFO_Empty);
    end
  endtask

  initial begin
    test_reset();
    test_empty_read();
    test_fill();
    test_overflow();
    test_drain();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_queue_32_bit.md
FIFO_QUEUE_32_BIT -- requirements
Module: fifo_queue_32_bit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, number of storage entries; power of two, at least 2.
REQ-003 The block SHALL have port Clk_In  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Reset_In  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port Data_In  input  DATA_WIDTH  write data.
REQ-006 The block SHALL have port Write_Enable_In  input  1  write request for the current cycle.
REQ-007 The block SHALL have port Read_Enable_In  input  1  read request for the current cycle.
REQ-008 The block SHALL have port Data_Out  output  DATA_WIDTH  registered read data.
REQ-009 The block SHALL have port FIFO_Empty  output  1  high when occupancy is 0.
REQ-010 The block SHALL have port FIFO_Full  output  1  high when occupancy equals DEPTH.
REQ-011 With FIFO_QUEUE_ERR_FLAGS_EN defined, the block SHALL add ports Overflow_Out and Underflow_Out, both output, 1 bit.

Function
REQ-012 Storage SHALL be DEPTH x DATA_WIDTH, with write pointer, read pointer and occupancy counter of log2(DEPTH)+1 bits.
REQ-013 A write SHALL be accepted when Write_Enable_In=1 and not full (or full with an accepted read, per REQ-018); Data_In is stored at the write pointer and the pointer increments, wrapping from DEPTH-1 to 0.
REQ-014 A read SHALL be accepted when Read_Enable_In=1 and not empty; the entry at the read pointer is loaded into Data_Out on that clock edge (1-cycle latency) and the pointer increments with wrap.
REQ-015 Data_Out SHALL hold its last value on cycles without an accepted read.
REQ-016 A write to a full FIFO without an accepted read SHALL be ignored: no storage, pointer or count change.
REQ-017 A read from an empty FIFO SHALL be ignored; Data_Out holds and pointers are unchanged.
REQ-018 With simultaneous read and write: when empty, only the write takes effect; when full, both take effect and occupancy stays DEPTH; otherwise both take effect and occupancy is unchanged.
REQ-019 FIFO_Empty and FIFO_Full SHALL be decoded combinationally from the occupancy counter and reflect the state after the most recent edge.
REQ-020 Data SHALL leave in strict write order across pointer wrap-around.

Reset
REQ-021 Reset_In=0 SHALL immediately clear the pointers, the occupancy counter and Data_Out to 0, giving FIFO_Empty=1 and FIFO_Full=0, regardless of the clock.
REQ-022 Storage contents need not be cleared; reset mid-operation discards all queued entries.
REQ-023 Reset_In SHALL be released synchronously to Clk_In by the integrator; the first accepted operation is on the first rising edge with Reset_In=1.

Configuration
REQ-024 Macro FIFO_QUEUE_ERR_FLAGS_EN defined: Overflow_Out SHALL pulse high for one cycle after a rejected write (REQ-016), and Underflow_Out for one cycle after a rejected read (REQ-017); both reset to 0.
REQ-025 Macro FIFO_QUEUE_ERR_FLAGS_EN undefined: those ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-026 Reset, then read with the FIFO empty -> Data_Out=0, FIFO_Empty=1, pointers unchanged (Underflow_Out pulses when the macro is defined).
REQ-027 Write 8 words 0x11111111..0x88888888 on consecutive cycles -> FIFO_Full=1 after the 8th edge, FIFO_Empty=0 after the 1st.
REQ-028 While full, write 0xDEADBEEF -> ignored, FIFO_Full stays 1 (Overflow_Out pulses when the macro is defined); 8 reads then return 0x11111111..0x88888888 in order, one cycle after each read edge.
REQ-029 After 8 reads -> FIFO_Empty=1; a 9th read leaves Data_Out=0x88888888.
REQ-030 With occupancy 3, read and write together for 10 cycles -> occupancy stays 3, order is preserved through wrap, and 8 simultaneous read+write operations while full keep FIFO_Full=1.
REQ-031 Assert Reset_In=0 between clock edges at occupancy 5 -> FIFO_Empty=1 and Data_Out=0 immediately, without waiting for a clock edge.
